// File: rtl/autoscale_pkg.sv
// autoscale_pkg
// Shared definitions for the autoscale / autoscale_restore pair in the FRB
// spectrum path: default shift limits, the shift type width, the framing FSM
// state enum and the shift clamp helper. No ports (package).
package autoscale_pkg;

    localparam int SHIFT_W       = 6;
    localparam int MIN_SHIFT_DEF = 4;
    localparam int MAX_SHIFT_DEF = 14;

    typedef logic [SHIFT_W-1:0] shift_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // shift_eff = min(max(s, lo), hi); operands are zero-extended to 32 bits
    function automatic logic [31:0] clamp_shift(input logic [31:0] s,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
        logic [31:0] r;
        r = (s < lo) ? lo : s;
        r = (r > hi) ? hi : r;
        return r;
    endfunction

endpackage

// File: rtl/autoscale_restore_lane.sv
// autoscale_restore_lane
// Combinational restore for one stream: left-shift the scaled sample back to
// absolute scale, saturating to all-ones when any bit lands at or above
// DOUT_WIDTH.
// Ports:
//   din   in  DIN_WIDTH    scaled sample (unsigned)
//   shift in  SHIFT_WIDTH  clamped shift, never above MAX_SHIFT
//   dout  out DOUT_WIDTH   restored sample
//   sat   out 1            this stream saturated
module autoscale_restore_lane #(
    parameter int DIN_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 40,
    parameter int SHIFT_WIDTH = 6,
    parameter int MAX_SHIFT   = 14
) (
    input  logic [DIN_WIDTH-1:0]   din,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [DOUT_WIDTH-1:0]  dout,
    output logic                   sat
);

    // Wide enough that the largest legal shift never loses bits.
    localparam int FULL_W = DIN_WIDTH + MAX_SHIFT;

    logic [FULL_W-1:0] full;

    always_comb begin
        full = FULL_W'(din) << shift;
    end

    generate
        if (FULL_W > DOUT_WIDTH) begin : g_sat
            always_comb begin
                sat  = |full[FULL_W-1:DOUT_WIDTH];
                dout = sat ? {DOUT_WIDTH{1'b1}} : full[DOUT_WIDTH-1:0];
            end
        end else begin : g_nosat
            // Output is wide enough for every legal shift: overflow impossible.
            always_comb begin
                sat  = 1'b0;
                dout = DOUT_WIDTH'(full);
            end
        end
    endgenerate

endmodule

// File: rtl/autoscale_restore.sv
// autoscale_restore
// Inverse of the autoscale stage: restores two autoscaled unsigned spectral
// streams to absolute power scale using the per-frame shift latched on the
// frame sync. Frame-synchronous with framing-error detection/resync; 2-stage
// pipeline, 1 sample/cycle, no backpressure.
// Optional: define AUTOSCALE_RESTORE_STATS_EN to add sat_count, the number of
// saturated samples in the last completed frame, reported on the next frame's
// sync_out.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   din1, din2      scaled input streams
//   din_valid       input qualifier
//   sync_in         first sample of a frame (qualified by din_valid)
//   shift_value     scaler shift for this frame (sampled on qualified sync)
//   dout1, dout2    restored streams (hold when dout_valid=0)
//   dout_valid      output qualifier
//   sync_out        first output sample of a frame
//   shift_applied   clamped shift of the current output frame
//   sat_flag        dout1 or dout2 saturated on this sample
//   sat_count       (stats build only) saturations in last completed frame
//   frame_err       one-cycle framing-violation pulse, output-stage timing
module autoscale_restore
    import autoscale_pkg::*;
#(
    parameter int DIN_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 40,
    parameter int SHIFT_WIDTH = SHIFT_W,
    parameter int MIN_SHIFT   = MIN_SHIFT_DEF,
    parameter int MAX_SHIFT   = MAX_SHIFT_DEF,
    parameter int FRAME_LEN   = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIN_WIDTH-1:0]   din1,
    input  logic [DIN_WIDTH-1:0]   din2,
    input  logic                   din_valid,
    input  logic                   sync_in,
    input  logic [SHIFT_WIDTH-1:0] shift_value,
    output logic [DOUT_WIDTH-1:0]  dout1,
    output logic [DOUT_WIDTH-1:0]  dout2,
    output logic                   dout_valid,
    output logic                   sync_out,
    output logic [SHIFT_WIDTH-1:0] shift_applied,
    output logic                   sat_flag,
`ifdef AUTOSCALE_RESTORE_STATS_EN
    output logic [15:0]            sat_count,
`endif
    output logic                   frame_err
);

    localparam int NUM_LANES = 2;
    localparam int STAGES    = 2;
    localparam int CNT_W     = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);

    // ---------------- framing FSM (input side) ----------------
    state_e                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [SHIFT_WIDTH-1:0] shift_r, shift_n;
    logic [SHIFT_WIDTH-1:0] shift_clamped;
    logic                   accept, err_in;

    always_comb begin
        shift_clamped = SHIFT_WIDTH'(clamp_shift(32'(shift_value),
                                                 32'(MIN_SHIFT),
                                                 32'(MAX_SHIFT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shift_r <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shift_r <= shift_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift_r;
        accept  = 1'b0;
        err_in  = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid && sync_in) begin
                    accept  = 1'b1;
                    cnt_n   = CNT_W'(1);
                    shift_n = shift_clamped;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (din_valid) begin
                    if (sync_in) begin
                        // Early sync truncates the running frame; it still
                        // starts the new one.
                        accept  = 1'b1;
                        err_in  = (cnt != CNT_FULL);
                        cnt_n   = CNT_W'(1);
                        shift_n = shift_clamped;
                    end else if (cnt == CNT_FULL) begin
                        // Missing sync: drop and wait for the next sync.
                        err_in  = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        accept  = 1'b1;
                        cnt_n   = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ---------------- stage 1 ----------------
    logic [NUM_LANES-1:0][DIN_WIDTH-1:0]  s1_din;
    logic [SHIFT_WIDTH-1:0]               s1_shift;
    logic                                 s1_sync, s1_err;
    logic [STAGES:1]                      vld_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_din   <= '0;
            s1_shift <= '0;
            s1_sync  <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_err  <= err_in;
            s1_sync <= accept & sync_in;
            if (accept) begin
                s1_din   <= {din2, din1};
                s1_shift <= shift_n;
            end
        end
    end

    // ---------------- lanes ----------------
    logic [NUM_LANES-1:0][DOUT_WIDTH-1:0] lane_dout;
    logic [NUM_LANES-1:0]                 lane_sat;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            autoscale_restore_lane #(
                .DIN_WIDTH  (DIN_WIDTH),
                .DOUT_WIDTH (DOUT_WIDTH),
                .SHIFT_WIDTH(SHIFT_WIDTH),
                .MAX_SHIFT  (MAX_SHIFT)
            ) u_lane (
                .din  (s1_din[g]),
                .shift(s1_shift),
                .dout (lane_dout[g]),
                .sat  (lane_sat[g])
            );
        end
    endgenerate

    // ---------------- stage 2 (outputs) ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe      <= '0;
            dout1         <= '0;
            dout2         <= '0;
            sync_out      <= 1'b0;
            shift_applied <= '0;
            sat_flag      <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], accept};
            frame_err <= s1_err;
            sync_out  <= vld_pipe[1] & s1_sync;
            sat_flag  <= vld_pipe[1] & (|lane_sat);
            if (vld_pipe[1]) begin
                dout1 <= lane_dout[0];
                dout2 <= lane_dout[1];
                if (s1_sync) shift_applied <= s1_shift;
            end
        end
    end

    assign dout_valid = vld_pipe[STAGES];

`ifdef AUTOSCALE_RESTORE_STATS_EN
    // Counted at output timing so the report lands exactly on sync_out.
    // frame_ok: the frame now in flight started cleanly and has not been
    // followed by a framing error, so its count may be reported.
    logic [15:0] sat_acc;
    logic        frame_ok;
    logic        s1_sat;

    assign s1_sat = |lane_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_acc   <= '0;
            sat_count <= '0;
            frame_ok  <= 1'b0;
        end else if (vld_pipe[1] && s1_sync) begin
            if (frame_ok && !s1_err) sat_count <= sat_acc;
            sat_acc  <= {15'd0, s1_sat};
            frame_ok <= 1'b1;
        end else begin
            if (s1_err) frame_ok <= 1'b0;
            if (vld_pipe[1] && s1_sat && sat_acc != 16'hFFFF)
                sat_acc <= sat_acc + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_autoscale_restore.sv
// tb_autoscale_restore
// Directed bench for autoscale_restore with FRAME_LEN=4. Each drive() call
// presents one input cycle; after it returns, the outputs reflect the
// previous drive() call (2-cycle latency).
module tb_autoscale_restore;

    localparam int DW = 32;
    localparam int OW = 40;
    localparam int SW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din1 = '0, din2 = '0;
    logic          din_valid = 1'b0, sync_in = 1'b0;
    logic [SW-1:0] shift_value = '0;
    logic [OW-1:0] dout1, dout2;
    logic          dout_valid, sync_out, sat_flag, frame_err;
    logic [SW-1:0] shift_applied;
`ifdef AUTOSCALE_RESTORE_STATS_EN
    logic [15:0]   sat_count;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    autoscale_restore #(
        .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .SHIFT_WIDTH(SW),
        .MIN_SHIFT(4), .MAX_SHIFT(14), .FRAME_LEN(4)
    ) dut (
        .clk(clk), .rst(rst), .din1(din1), .din2(din2),
        .din_valid(din_valid), .sync_in(sync_in), .shift_value(shift_value),
        .dout1(dout1), .dout2(dout2), .dout_valid(dout_valid),
        .sync_out(sync_out), .shift_applied(shift_applied),
        .sat_flag(sat_flag),
`ifdef AUTOSCALE_RESTORE_STATS_EN
        .sat_count(sat_count),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [SW-1:0] sh);
        din_valid   = v;
        sync_in     = s;
        din1        = a;
        din2        = b;
        shift_value = sh;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout1", dout1, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_shift", shift_applied, 0);
        chk("rst_err", frame_err, 0);
        rst = 1'b0;

        // valid without sync in IDLE is dropped
        drive(1, 0, 5, 5, 9);
        drive(0, 0, 0, 0, 0);
        chk("idle_drop_valid", dout_valid, 0);

        // frame 1: nominal shift 6
        drive(1, 1, 32'h1, 32'hFFFF, 6);                 // s0
        drive(1, 0, 2, 3, 0);                            // s1
        chk("nom_valid", dout_valid, 1);
        chk("nom_sync", sync_out, 1);
        chk("nom_d1", dout1, 64'h40);
        chk("nom_d2", dout2, 64'h3FFFC0);
        chk("nom_shift", shift_applied, 6);
        chk("nom_sat", sat_flag, 0);
        chk("nom_err", frame_err, 0);
        drive(1, 0, 4, 5, 0);                            // s2
        chk("f1s1_d1", dout1, 64'h80);
        chk("f1s1_d2", dout2, 64'hC0);
        chk("f1s1_sync", sync_out, 0);
        drive(1, 0, 8, 0, 0);                            // s3
        chk("f1s2_d1", dout1, 64'h100);

        // frame 2: clamp low (2 -> 4)
        drive(1, 1, 1, 1, 2);                            // s4
        chk("f1s3_d1", dout1, 64'h200);
        chk("f1s3_shift_hold", shift_applied, 6);
        drive(1, 0, 0, 0, 0);                            // s5
        chk("clamp_lo_sync", sync_out, 1);
        chk("clamp_lo_shift", shift_applied, 4);
        chk("clamp_lo_d1", dout1, 64'h10);
        chk("normal_sync_noerr", frame_err, 0);
        drive(1, 0, 0, 0, 0);                            // s6
        drive(1, 0, 0, 0, 0);                            // s7

        // frame 3: clamp high (20 -> 14) and saturation
        drive(1, 1, 32'hFFFFFFFF, 32'h3FFFFFF, 20);      // s8
        drive(1, 0, 32'hFFFFFFFF, 0, 0);                 // s9
        chk("clamp_hi_shift", shift_applied, 14);
        chk("sat_d1", dout1, 64'hFF_FFFF_FFFF);
        chk("sat_d2_exact", dout2, 64'hFF_FFFF_C000);
        chk("sat_flag", sat_flag, 1);
        drive(1, 0, 32'hFFFFFFFF, 0, 0);                 // s10
        chk("sat2_flag", sat_flag, 1);
        chk("sat2_d2", dout2, 0);
        drive(1, 0, 1, 1, 0);                            // s11
        chk("sat3_flag", sat_flag, 1);

        // frame 4: early sync on 3rd sample
        drive(1, 1, 1, 1, 6);                            // s12
        chk("nosat_flag", sat_flag, 0);
        chk("nosat_d1", dout1, 64'h4000);
        drive(1, 0, 2, 2, 0);                            // s13
        chk("f4_sync", sync_out, 1);
        chk("f4_d1", dout1, 64'h40);
`ifdef AUTOSCALE_RESTORE_STATS_EN
        chk("stats_count3", sat_count, 3);
`endif
        drive(1, 1, 1, 1, 8);                            // s14 early sync
        chk("pre_early_err", frame_err, 0);
        chk("f4s1_d1", dout1, 64'h80);
        drive(1, 0, 0, 0, 0);                            // s15
        chk("early_err", frame_err, 1);
        chk("early_sync", sync_out, 1);
        chk("early_valid", dout_valid, 1);
        chk("early_shift", shift_applied, 8);
        chk("early_d1", dout1, 64'h100);
        drive(1, 0, 0, 0, 0);                            // s16
        chk("early_err_pulse", frame_err, 0);
        drive(1, 0, 5, 5, 0);                            // s17 (4th sample)
        drive(1, 0, 7, 7, 0);                            // s18 missing sync
        chk("f5s3_d1", dout1, 64'h500);
        drive(1, 0, 9, 9, 0);                            // s19 dropped in IDLE
        chk("miss_err", frame_err, 1);
        chk("miss_valid", dout_valid, 0);
        chk("miss_d1_hold", dout1, 64'h500);
        drive(1, 1, 3, 3, 6);                            // s20 resync
        chk("idle_after_err_valid", dout_valid, 0);
        chk("idle_after_err_err", frame_err, 0);
        drive(0, 1, 9, 9, 3);                            // sync without valid
        chk("resync_sync", sync_out, 1);
        chk("resync_shift", shift_applied, 6);
        chk("resync_d1", dout1, 64'hC0);
`ifdef AUTOSCALE_RESTORE_STATS_EN
        chk("stats_abort_hold", sat_count, 3);
`endif
        drive(1, 0, 4, 4, 0);                            // s21
        chk("unq_sync_valid", dout_valid, 0);
        chk("unq_sync_out", sync_out, 0);
        drive(1, 0, 6, 6, 0);                            // s22
        chk("unq_noshift_d1", dout1, 64'h100);
        chk("unq_noshift_shift", shift_applied, 6);
        chk("unq_nosync", sync_out, 0);

        // mid-frame reset: s22 is in flight
        rst = 1'b1;
        #1;
        chk("mrst_d1", dout1, 0);
        chk("mrst_valid", dout_valid, 0);
        chk("mrst_shift", shift_applied, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk("mrst_flush_valid", dout_valid, 0);
        drive(0, 0, 0, 0, 0);
        chk("mrst_flush_valid2", dout_valid, 0);
        chk("mrst_flush_d1", dout1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
